// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- pipeline MEM stage.
//
// Sits directly after the execute stage and consumes its *_EXMEM outputs.
// Performs the data-memory access over a req/done handshake, holds the
// upstream pipeline with stall_MEM until the access completes, and drives
// the MEM/WB register feeding writeback. Misaligned accesses, simultaneous
// load+store and accesses that time out raise the sticky err flag. Once a
// halt instruction retires, the stage parks in HALTED until reset.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   *_EXMEM               instruction fields from the EX/MEM register
//   mem_req/we/addr/wdata request to data memory, held until mem_done
//   mem_rdata, mem_done   memory response (done may arrive with req)
//   mem_dump              one-cycle pulse as the halt instruction retires
//   stall_MEM             hold EX/MEM and everything upstream this cycle
//   *_MEMWB               registered MEM/WB fields for writeback
//   err                   sticky error, cleared only by rst
// ---------------------------------------------------------------------------
module mem_stage #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ALUO_EXMEM,
  input  logic [15:0] Rd2_EXMEM,
  input  logic [2:0]  WrR_EXMEM,
  input  logic        RegWrite_EXMEM,
  input  logic        MemtoReg_EXMEM,
  input  logic        MemRead_EXMEM,
  input  logic        MemWrite_EXMEM,
  input  logic        Dump_EXMEM,
  input  logic        halt_EXMEM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_dump,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic        stall_MEM,
  output logic [15:0] ALUO_MEMWB,
  output logic [15:0] MemData_MEMWB,
  output logic [2:0]  WrR_MEMWB,
  output logic        RegWrite_MEMWB,
  output logic        MemtoReg_MEMWB,
  output logic        halt_MEMWB,
  output logic        err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] wait_cnt, wait_cnt_nx;
  logic          mem_op, bad, acc;
  logic          capture;   // MEM/WB takes the EX/MEM instruction this edge
  logic          set_err;

  assign mem_op = MemRead_EXMEM | MemWrite_EXMEM;

  // Only a fresh instruction in IDLE is screened; the one held during BUSY
  // already passed, and nothing is accessed once halted.
  assign bad = (state == IDLE) &
               ((MemRead_EXMEM & MemWrite_EXMEM) | (mem_op & ALUO_EXMEM[0]));
  assign acc = mem_op & ~bad & (state != HALTED);

  // Request fields are zeroed when no request is outstanding.
  assign mem_we    = mem_req & MemWrite_EXMEM;
  assign mem_addr  = mem_req ? ALUO_EXMEM : 16'h0000;
  assign mem_wdata = mem_req ? Rd2_EXMEM  : 16'h0000;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    mem_req     = 1'b0;
    stall_MEM   = 1'b0;
    capture     = 1'b0;
    set_err     = 1'b0;
    unique case (state)
      IDLE: begin
        mem_req = acc;
        if (bad) begin
          set_err = 1'b1;                 // dropped as a bubble, no request
        end else if (acc && !mem_done) begin
          stall_MEM   = 1'b1;
          state_nx    = BUSY;
          wait_cnt_nx = CW'(1);
        end else begin
          capture = 1'b1;
          if (halt_EXMEM) state_nx = HALTED;
        end
      end
      BUSY: begin
        if (wait_cnt == CW'(TIMEOUT)) begin
          // Give up: release the pipeline so the instruction leaves as a
          // bubble instead of being re-presented and re-issued.
          set_err     = 1'b1;
          state_nx    = IDLE;
          wait_cnt_nx = '0;
        end else begin
          mem_req = 1'b1;
          if (mem_done) begin
            capture     = 1'b1;
            state_nx    = halt_EXMEM ? HALTED : IDLE;
            wait_cnt_nx = '0;
          end else begin
            stall_MEM   = 1'b1;
            wait_cnt_nx = wait_cnt + CW'(1);
          end
        end
      end
      HALTED: begin
        // Parked: no requests, no stalls, bubbles flow into MEM/WB.
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    if (rst) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      err            <= 1'b0;
      mem_dump       <= 1'b0;
      ALUO_MEMWB     <= '0;
      MemData_MEMWB  <= '0;
      WrR_MEMWB      <= '0;
      RegWrite_MEMWB <= 1'b0;
      MemtoReg_MEMWB <= 1'b0;
      halt_MEMWB     <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      if (set_err) err <= 1'b1;
      mem_dump <= capture & (halt_EXMEM | Dump_EXMEM);
      if (capture) begin
        ALUO_MEMWB     <= ALUO_EXMEM;
        MemData_MEMWB  <= MemRead_EXMEM ? mem_rdata : 16'h0000;
        WrR_MEMWB      <= WrR_EXMEM;
        RegWrite_MEMWB <= RegWrite_EXMEM;
        MemtoReg_MEMWB <= MemtoReg_EXMEM;
        halt_MEMWB     <= halt_EXMEM;
      end else begin
        ALUO_MEMWB     <= '0;
        MemData_MEMWB  <= '0;
        WrR_MEMWB      <= '0;
        RegWrite_MEMWB <= 1'b0;
        MemtoReg_MEMWB <= 1'b0;
        halt_MEMWB     <= (state == HALTED);  // halt stays visible once parked
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage -- self-checking bench for mem_stage (TIMEOUT = 4).
//
// Acts as the upstream EX/MEM register and as the data memory. Each
// instruction is predicted at the instruction level: whether it accesses
// memory, how many cycles it stalls given the chosen memory latency, and
// what record it leaves in MEM/WB.
// ---------------------------------------------------------------------------
module tb_mem_stage;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ALUO_EXMEM, Rd2_EXMEM, mem_rdata;
  logic [2:0]  WrR_EXMEM;
  logic        RegWrite_EXMEM, MemtoReg_EXMEM, MemRead_EXMEM, MemWrite_EXMEM;
  logic        Dump_EXMEM, halt_EXMEM, mem_done;
  logic        mem_req, mem_we, mem_dump, stall_MEM, err;
  logic [15:0] mem_addr, mem_wdata, ALUO_MEMWB, MemData_MEMWB;
  logic [2:0]  WrR_MEMWB;
  logic        RegWrite_MEMWB, MemtoReg_MEMWB, halt_MEMWB;

  mem_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .ALUO_EXMEM     (ALUO_EXMEM),
    .Rd2_EXMEM      (Rd2_EXMEM),
    .WrR_EXMEM      (WrR_EXMEM),
    .RegWrite_EXMEM (RegWrite_EXMEM),
    .MemtoReg_EXMEM (MemtoReg_EXMEM),
    .MemRead_EXMEM  (MemRead_EXMEM),
    .MemWrite_EXMEM (MemWrite_EXMEM),
    .Dump_EXMEM     (Dump_EXMEM),
    .halt_EXMEM     (halt_EXMEM),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_dump       (mem_dump),
    .mem_rdata      (mem_rdata),
    .mem_done       (mem_done),
    .stall_MEM      (stall_MEM),
    .ALUO_MEMWB     (ALUO_MEMWB),
    .MemData_MEMWB  (MemData_MEMWB),
    .WrR_MEMWB      (WrR_MEMWB),
    .RegWrite_MEMWB (RegWrite_MEMWB),
    .MemtoReg_MEMWB (MemtoReg_MEMWB),
    .halt_MEMWB     (halt_MEMWB),
    .err            (err)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   nbad  = 0;
  logic err_m;      // reference: sticky error
  logic halted_m;   // reference: a halt has retired

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] memwb_now();
    return {26'd0, ALUO_MEMWB, MemData_MEMWB, WrR_MEMWB,
            RegWrite_MEMWB, MemtoReg_MEMWB, halt_MEMWB};
  endfunction

  task automatic clear_inputs();
    ALUO_EXMEM = '0; Rd2_EXMEM = '0; WrR_EXMEM = '0;
    RegWrite_EXMEM = 0; MemtoReg_EXMEM = 0; MemRead_EXMEM = 0;
    MemWrite_EXMEM = 0; Dump_EXMEM = 0; halt_EXMEM = 0;
    mem_done = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("reset_memwb", memwb_now(), 64'd0);
    check("reset_err", err, 1'b0);
    check("reset_dump", mem_dump, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_req", mem_req, 1'b0);
    check("reset_stall", stall_MEM, 1'b0);
    err_m    = 1'b0;
    halted_m = 1'b0;
  endtask

  // Present one instruction and play memory with done arriving 'lat' cycles
  // after the request first appears (lat >= TIMEOUT means it never arrives
  // in time).
  task automatic do_instr(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [2:0] dst,
                          input logic rw, input logic hlt, input int lat,
                          input logic [15:0] rdata);
    logic        is_bad, is_acc, ok, dump_exp;
    int          kf;
    logic [63:0] exp_rec;
    is_bad   = !halted_m && ((rd && wr) || ((rd || wr) && addr[0]));
    is_acc   = (rd || wr) && !is_bad && !halted_m;
    ok       = !is_acc || (lat < TIMEOUT);
    kf       = !is_acc ? 0 : (ok ? lat : TIMEOUT);
    if (halted_m)             exp_rec = 64'd1;
    else if (is_bad || !ok)   exp_rec = 64'd0;
    else exp_rec = {26'd0, addr, (rd ? rdata : 16'h0000), dst, rw, rd, hlt};
    dump_exp = hlt && !halted_m && !is_bad && ok;
    for (int k = 0; k <= kf; k++) begin
      @(negedge clk);
      ALUO_EXMEM = addr; Rd2_EXMEM = wdata; WrR_EXMEM = dst;
      RegWrite_EXMEM = rw; MemtoReg_EXMEM = rd; MemRead_EXMEM = rd;
      MemWrite_EXMEM = wr; Dump_EXMEM = hlt; halt_EXMEM = hlt;
      mem_done  = is_acc ? (k == lat) : 1'($urandom_range(0, 1));
      mem_rdata = (is_acc && k == lat) ? rdata : 16'($urandom);
      #1;
      check("mem_req", mem_req, is_acc && !(!ok && k == kf));
      check("stall", stall_MEM, k < kf);
      if (is_acc && !(!ok && k == kf)) begin
        check("mem_addr", mem_addr, addr);
        check("mem_we", mem_we, wr);
        check("mem_wdata", mem_wdata, wdata);
      end
      @(posedge clk);
      #1;
      if (k < kf) check("bubble", memwb_now(), 64'd0);
      else        check("retire", memwb_now(), exp_rec);
      check("mem_dump", mem_dump, (k == kf) && dump_exp);
    end
    if (is_bad || !ok) err_m = 1'b1;
    if (dump_exp)      halted_m = 1'b1;
    check("err", err, err_m);
  endtask

  // Reset lands while a load waits in BUSY; a late done must be ignored.
  task automatic reset_mid_busy();
    @(negedge clk);
    ALUO_EXMEM = 16'h0030; MemRead_EXMEM = 1; MemtoReg_EXMEM = 1;
    RegWrite_EXMEM = 1; WrR_EXMEM = 3'd5; mem_done = 0;
    #1;
    check("rmb_req0", mem_req, 1'b1);
    @(negedge clk);
    #1;
    check("rmb_stall1", stall_MEM, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rmb_memwb", memwb_now(), 64'd0);
    check("rmb_err", err, 1'b0);
    clear_inputs();              // upstream register resets on the same edge
    rst = 1'b0;
    @(negedge clk);
    mem_done  = 1'b1;
    mem_rdata = 16'hDEAD;
    #1;
    check("rmb_req", mem_req, 1'b0);
    check("rmb_stall", stall_MEM, 1'b0);
    @(posedge clk);
    #1;
    check("rmb_late_done", memwb_now(), 64'd0);
    check("rmb_dump", mem_dump, 1'b0);
    @(negedge clk);
    mem_done = 1'b0;
    err_m    = 1'b0;
    halted_m = 1'b0;
  endtask

  initial begin
    logic        rd, wr, rw;
    logic [15:0] addr;
    int          kind;
    rst = 1'b1;
    clear_inputs();
    err_m = 1'b0;
    halted_m = 1'b0;
    do_reset();

    // directed cases
    do_instr(1, 0, 16'h0010, 16'h0000, 3'd3, 1, 0, 0, 16'hBEEF);      // load, zero wait
    do_instr(0, 1, 16'h0020, 16'h1234, 3'd0, 0, 0, 3, 16'h0000);      // store, 3 stalls
    do_instr(0, 0, 16'h00A5, 16'h0000, 3'd2, 1, 0, 0, 16'h0000);      // ALU op
    do_instr(1, 0, 16'h0022, 16'h0000, 3'd1, 1, 0, TIMEOUT - 1, 16'h55AA); // last good cycle
    do_instr(1, 0, 16'h0011, 16'h0000, 3'd4, 1, 0, 0, 16'h1111);      // misaligned
    do_instr(0, 0, 16'h0002, 16'h0000, 3'd6, 1, 0, 0, 16'h0000);      // err stays set
    do_reset();
    do_instr(1, 0, 16'h0040, 16'h0000, 3'd7, 1, 0, TIMEOUT, 16'h2222); // done too late
    do_instr(1, 0, 16'h0042, 16'h0000, 3'd7, 1, 0, 0, 16'h3333);      // back in IDLE
    do_reset();
    do_instr(1, 1, 16'h0044, 16'h9999, 3'd1, 1, 0, 0, 16'h0000);      // load+store conflict

    // randomized traffic
    do_reset();
    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 9);
      rd   = (kind <= 3) || (kind == 7);
      wr   = (kind >= 4 && kind <= 7);
      addr = 16'($urandom);
      if ($urandom_range(0, 4) != 0) addr[0] = 1'b0;
      rw   = rd ? 1'b1 : 1'($urandom_range(0, 1));
      do_instr(rd, wr, addr, 16'($urandom), 3'($urandom), rw, 0,
               $urandom_range(0, TIMEOUT + 1), 16'($urandom));
    end

    do_reset();
    reset_mid_busy();

    // halt behind a stalled load, then nothing more may issue
    do_instr(1, 0, 16'h0050, 16'h0000, 3'd2, 1, 0, 2, 16'hCAFE);
    do_instr(0, 0, 16'h0000, 16'h0000, 3'd0, 0, 1, 0, 16'h0000);
    do_instr(1, 0, 16'h0060, 16'h0000, 3'd3, 1, 0, 0, 16'h7777);
    do_instr(0, 1, 16'h0062, 16'h4321, 3'd0, 0, 0, 1, 16'h0000);
    do_instr(0, 0, 16'h0008, 16'h0000, 3'd4, 1, 0, 0, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, nbad);
    $finish;
  end

endmodule
